keypad_scan: RTL

- Scans a 4x4 active-low matrix keypad for game input (player moves, start/pause).
- Drives one column low at a time, in the same rotating one-low pattern used on the display digit enables.
- Samples the row lines, debounces over whole scan frames, and reports one code per press.
- Sits between the keypad pins and the game control FSM.

---
 rtl/keypad_scan_pkg.sv | 46 ++++
 rtl/keypad_debounce.sv | 108 ++++++++++
 rtl/keypad_scan.sv | 92 +++++++++
 3 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: column drive patterns,
// debounce FSM states and the game key mapping.
package keypad_scan_pkg;

    localparam logic [3:0] COL_DRIVE_0 = 4'b0111;
    localparam logic [3:0] COL_DRIVE_1 = 4'b1011;
    localparam logic [3:0] COL_DRIVE_2 = 4'b1101;
    localparam logic [3:0] COL_DRIVE_3 = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } db_state_t;

    // Game mapping, code = row*4 + col
    localparam logic [3:0] KEY_UP    = 4'd1;
    localparam logic [3:0] KEY_START = 4'd3;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_DOWN  = 4'd9;
    localparam logic [3:0] KEY_PAUSE = 4'd15;

    function automatic logic [3:0] col_drive(input logic [1:0] sel);
        logic [3:0] drive;
        case (sel)
            2'd0:    drive = COL_DRIVE_0;
            2'd1:    drive = COL_DRIVE_1;
            2'd2:    drive = COL_DRIVE_2;
            default: drive = COL_DRIVE_3;
        endcase
        return drive;
    endfunction

    // Index of the lowest row line pulled low; only meaningful if one is low.
    function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: accepts a press or release only after DEBOUNCE
// consecutive frames agree, and pulses o_key_valid once per accepted press.
module keypad_debounce
    import keypad_scan_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_tick,
    input  logic       i_frame_hit,
    input  logic [3:0] i_frame_code,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_down
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    db_state_t     r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic [3:0]    r_cand, w_cand_next;
    logic [3:0]    r_key_code, w_key_code_next;
    logic          r_key_valid, w_key_valid_next;
    logic          r_key_down, w_key_down_next;
    logic          w_cnt_done;

    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_cnt_done = (w_cnt_inc == CW'(DEBOUNCE));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_cand      <= w_cand_next;
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_key_valid_next;
            r_key_down  <= w_key_down_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_cand_next      = r_cand;
        w_key_code_next  = r_key_code;
        w_key_valid_next = 1'b0;
        w_key_down_next  = r_key_down;
        if (i_frame_tick) begin
            case (r_state)
                IDLE: begin
                    if (i_frame_hit) begin
                        w_cand_next  = i_frame_code;
                        w_cnt_next   = CW'(1);
                        w_state_next = PRESS_CHK;
                    end
                end
                PRESS_CHK: begin
                    if (i_frame_hit && (i_frame_code == r_cand)) begin
                        if (w_cnt_done) begin
                            w_state_next     = HELD;
                            w_key_code_next  = r_cand;
                            w_key_down_next  = 1'b1;
                            w_key_valid_next = 1'b1;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else if (i_frame_hit) begin
                        w_cand_next = i_frame_code;
                        w_cnt_next  = CW'(1);
                    end else begin
                        w_state_next = IDLE;
                    end
                end
                HELD: begin
                    if (!i_frame_hit) begin
                        w_cnt_next   = CW'(1);
                        w_state_next = RELEASE_CHK;
                    end
                end
                RELEASE_CHK: begin
                    if (i_frame_hit) begin
                        // Bounce or rollover: no new press until a full release
                        w_state_next = HELD;
                    end else if (w_cnt_done) begin
                        w_state_next    = IDLE;
                        w_key_down_next = 1'b0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_down  = r_key_down;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: rotates the column drive, synchronizes the
// rows, reduces each scan frame to one hit/code and feeds the debouncer.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_key_row,
    output logic [3:0] o_key_col,
    output logic [1:0] o_scan_sel,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_down
);

    localparam int unsigned DW = $clog2(SCAN_DIV);

    logic [DW-1:0] r_dwell;
    logic [1:0]    r_scan_sel;
    logic [3:0]    r_sync1, r_sync2;
    logic          r_frame_hit;
    logic [3:0]    r_frame_code;

    logic          w_tc;
    logic          w_frame_tick;
    logic          w_row_hit;
    logic [3:0]    w_sample_code;
    logic          w_cur_hit;
    logic [3:0]    w_cur_code;

    assign w_tc         = (r_dwell == DW'(SCAN_DIV - 1));
    assign w_frame_tick = w_tc && (r_scan_sel == 2'd3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dwell    <= '0;
            r_scan_sel <= 2'd0;
            r_sync1    <= 4'b1111;
            r_sync2    <= 4'b1111;
        end else begin
            r_sync1 <= i_key_row;
            r_sync2 <= r_sync1;
            if (w_tc) begin
                r_dwell    <= '0;
                r_scan_sel <= r_scan_sel + 2'd1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // First hit in scan order wins: lowest column, then lowest row
    assign w_row_hit     = ~&r_sync2;
    assign w_sample_code = {low_row_idx(r_sync2), r_scan_sel};
    assign w_cur_hit     = r_frame_hit | w_row_hit;
    assign w_cur_code    = r_frame_hit ? r_frame_code : w_sample_code;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_hit  <= 1'b0;
            r_frame_code <= '0;
        end else if (w_tc) begin
            if (r_scan_sel == 2'd3) begin
                r_frame_hit  <= 1'b0;
                r_frame_code <= '0;
            end else begin
                r_frame_hit  <= w_cur_hit;
                r_frame_code <= w_cur_code;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_frame_tick(w_frame_tick),
        .i_frame_hit (w_cur_hit),
        .i_frame_code(w_cur_code),
        .o_key_code  (o_key_code),
        .o_key_valid (o_key_valid),
        .o_key_down  (o_key_down)
    );

    assign o_key_col  = col_drive(r_scan_sel);
    assign o_scan_sel = r_scan_sel;

endmodule
